// File: rtl/mcu_control_pkg.sv
// Shared constants for the multicycle MIPS control unit: ALU function codes,
// opcode/funct encodings and the 4-bit controller state encoding.
package mcu_control_pkg;

   // ALU function-select codes (shared with the ALU)
   localparam logic [4:0] FS_PASS_S  = 5'h00;
   localparam logic [4:0] FS_PASS_R  = 5'h01;
   localparam logic [4:0] FS_ADD     = 5'h02;
   localparam logic [4:0] FS_ADDU    = 5'h03;
   localparam logic [4:0] FS_SUB     = 5'h04;
   localparam logic [4:0] FS_SUBU    = 5'h05;
   localparam logic [4:0] FS_SLT     = 5'h06;
   localparam logic [4:0] FS_SLTU    = 5'h07;
   localparam logic [4:0] FS_AND     = 5'h08;
   localparam logic [4:0] FS_OR      = 5'h09;
   localparam logic [4:0] FS_XOR     = 5'h0A;
   localparam logic [4:0] FS_NOR     = 5'h0B;
   localparam logic [4:0] FS_SRL     = 5'h0C;
   localparam logic [4:0] FS_SRA     = 5'h0D;
   localparam logic [4:0] FS_SLL     = 5'h0E;
   localparam logic [4:0] FS_SP_INIT = 5'h15;
   localparam logic [4:0] FS_ANDI    = 5'h16;
   localparam logic [4:0] FS_ORI     = 5'h17;
   localparam logic [4:0] FS_LUI     = 5'h18;
   localparam logic [4:0] FS_XORI    = 5'h19;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_EXEC_I   = 4'd4,
      S_WB_ALU   = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_LW_RD    = 4'd7,
      S_LW_WB    = 4'd8,
      S_SW_WR    = 4'd9,
      S_BR_CMP   = 4'd10,
      S_BR_TAKE  = 4'd11,
      S_JUMP     = 4'd12,
      S_HALT     = 4'd13
   } state_e;

   function automatic logic is_itype(input logic [5:0] op);
      return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
             (op == OP_ORI)  || (op == OP_XORI) || (op == OP_LUI);
   endfunction

endpackage

// File: rtl/mcu_control_fs_decode.sv
// Maps {opcode, funct} to an ALU function select; flags anything outside the
// supported R-type/immediate ALU set as illegal.
module fs_decode
   import mcu_control_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [4:0] fs,
   output logic       illegal
);

   always_comb begin
      fs      = FS_PASS_S;
      illegal = 1'b0;
      if (opcode == OP_RTYPE) begin
         case (funct)
            FN_ADD:  fs = FS_ADD;
            FN_ADDU: fs = FS_ADDU;
            FN_SUB:  fs = FS_SUB;
            FN_SUBU: fs = FS_SUBU;
            FN_AND:  fs = FS_AND;
            FN_OR:   fs = FS_OR;
            FN_XOR:  fs = FS_XOR;
            FN_NOR:  fs = FS_NOR;
            FN_SLT:  fs = FS_SLT;
            FN_SLTU: fs = FS_SLTU;
            FN_SRL:  fs = FS_SRL;
            FN_SRA:  fs = FS_SRA;
            FN_SLL:  fs = FS_SLL;
            default: illegal = 1'b1;
         endcase
      end else begin
         case (opcode)
            OP_ADDI: fs = FS_ADD;
            OP_SLTI: fs = FS_SLT;
            OP_ANDI: fs = FS_ANDI;
            OP_ORI:  fs = FS_ORI;
            OP_XORI: fs = FS_XORI;
            OP_LUI:  fs = FS_LUI;
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/mcu_control.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/write-back,
// drives datapath enables and selects, and latches ALU flags into psr.
module mcu_control
   import mcu_control_pkg::*;
#(
   parameter logic [4:0] SP_REG = 5'd29,
   parameter logic [4:0] RA_REG = 5'd31
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir,
   input  logic        c,
   input  logic        v,
   input  logic        n,
   input  logic        z,
   output logic        pc_ld,
   output logic        pc_inc,
   output logic        ir_ld,
   output logic        im_cs,
   output logic        im_rd,
   output logic        dm_cs,
   output logic        dm_rd,
   output logic        dm_wr,
   output logic        d_en,
   output logic [1:0]  da_sel,
   output logic        t_sel,
   output logic        y_sel,
   output logic [1:0]  pc_sel,
   output logic [4:0]  alu_fs,
   output logic [3:0]  psr,
   output logic        halt
);

   state_e     state, nxt;
   logic [5:0] opcode, funct;
   logic [4:0] dec_fs;
   logic       dec_ill;
   logic       psr_upd;

   assign opcode = ir[31:26];
   assign funct  = ir[5:0];

   fs_decode u_fs_decode (
      .opcode  (opcode),
      .funct   (funct),
      .fs      (dec_fs),
      .illegal (dec_ill)
   );

   assign psr_upd = (state == S_EXEC_R) || (state == S_EXEC_I) || (state == S_BR_CMP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_RESET;
         psr   <= 4'b0;
      end else begin
         state <= nxt;
         if (psr_upd) psr <= {c, v, n, z};
      end
   end

   always_comb begin
      nxt    = state;
      pc_ld  = 1'b0;
      pc_inc = 1'b0;
      ir_ld  = 1'b0;
      im_cs  = 1'b0;
      im_rd  = 1'b0;
      dm_cs  = 1'b0;
      dm_rd  = 1'b0;
      dm_wr  = 1'b0;
      d_en   = 1'b0;
      da_sel = 2'd0;
      t_sel  = 1'b0;
      y_sel  = 1'b0;
      pc_sel = 2'd0;
      alu_fs = FS_PASS_S;
      halt   = 1'b0;
      case (state)
         S_RESET: begin
            // ALU produces the stack-pointer init value, written to SP_REG
            alu_fs = FS_SP_INIT;
            d_en   = 1'b1;
            da_sel = 2'd2;
            nxt    = S_FETCH;
         end
         S_FETCH: begin
            im_cs  = 1'b1;
            im_rd  = 1'b1;
            ir_ld  = 1'b1;
            pc_inc = 1'b1;
            nxt    = S_DECODE;
         end
         S_DECODE: begin
            if (opcode == OP_RTYPE)                  nxt = S_EXEC_R;
            else if (is_itype(opcode))               nxt = S_EXEC_I;
            else if (opcode == OP_LW || opcode == OP_SW)   nxt = S_MEM_ADDR;
            else if (opcode == OP_BEQ || opcode == OP_BNE) nxt = S_BR_CMP;
            else if (opcode == OP_J)                 nxt = S_JUMP;
            else                                     nxt = S_HALT;
         end
         S_EXEC_R: begin
            alu_fs = dec_fs;
            nxt    = dec_ill ? S_HALT : S_WB_ALU;
         end
         S_EXEC_I: begin
            alu_fs = dec_fs;
            t_sel  = 1'b1;
            nxt    = S_WB_ALU;
         end
         S_WB_ALU: begin
            // ir is stable, so the decoder reproduces the EXEC-cycle operands
            alu_fs = dec_fs;
            t_sel  = (opcode != OP_RTYPE);
            d_en   = 1'b1;
            da_sel = (opcode == OP_RTYPE) ? 2'd0 : 2'd1;
            nxt    = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_fs = FS_ADD;
            t_sel  = 1'b1;
            nxt    = (opcode == OP_LW) ? S_LW_RD : S_SW_WR;
         end
         S_LW_RD: begin
            alu_fs = FS_ADD;
            t_sel  = 1'b1;
            dm_cs  = 1'b1;
            dm_rd  = 1'b1;
            nxt    = S_LW_WB;
         end
         S_LW_WB: begin
            dm_cs  = 1'b1;
            dm_rd  = 1'b1;
            d_en   = 1'b1;
            y_sel  = 1'b1;
            da_sel = 2'd1;
            nxt    = S_FETCH;
         end
         S_SW_WR: begin
            alu_fs = FS_ADD;
            t_sel  = 1'b1;
            dm_cs  = 1'b1;
            dm_wr  = 1'b1;
            nxt    = S_FETCH;
         end
         S_BR_CMP: begin
            // decision uses the live z flag, not the latched psr
            alu_fs = FS_SUB;
            if (((opcode == OP_BEQ) && z) || ((opcode == OP_BNE) && !z))
               nxt = S_BR_TAKE;
            else
               nxt = S_FETCH;
         end
         S_BR_TAKE: begin
            pc_sel = 2'd1;
            pc_ld  = 1'b1;
            nxt    = S_FETCH;
         end
         S_JUMP: begin
            pc_sel = 2'd2;
            pc_ld  = 1'b1;
            nxt    = S_FETCH;
         end
         S_HALT: begin
            halt = 1'b1;
            nxt  = S_HALT;
         end
         default: nxt = S_RESET;
      endcase
   end

endmodule

// File: doc/mcu_control.md
# mcu_control

Multicycle control unit for the 32-bit MIPS datapath. It is the producing end of the 5-bit ALU function-select interface. It sequences fetch, decode, execute, memory and write-back for a subset of MIPS instructions, and drives every datapath enable and mux select. It also latches the ALU status flags (C, V, N, Z) so that branches can use them in a later cycle.

## Interface
Parameters:
- SP_REG, 5'd29: register written during the reset sequence with the stack-pointer init value.
- RA_REG, 5'd31: reserved link register; not written by the supported set.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ir  in  32  instruction register contents, valid from DECODE onward
- c, v, n, z  in  1 each  ALU status flags for the current alu_fs
- pc_ld, pc_inc, ir_ld  out  1 each  PC load, PC+4 increment, IR load
- im_cs, im_rd  out  1 each  instruction memory select and read
- dm_cs, dm_rd, dm_wr  out  1 each  data memory select, read, write
- d_en  out  1  register file write enable
- da_sel  out  2  write address: 0=rd, 1=rt, 2=SP_REG
- t_sel  out  1  ALU T operand: 0=rt data, 1=sign-extended imm16
- y_sel  out  1  write-back data: 0=ALU Y_lo, 1=data memory
- pc_sel  out  2  PC source: 0=ALU Y_lo, 1=branch target, 2=jump target
- alu_fs  out  5  ALU function select
- psr  out  4  latched {C,V,N,Z}
- halt  out  1  high in HALT state

## Operation
- One state register. All outputs are Moore-decoded from the state and ir. In every state, any output not named for that state is 0.
- States and transitions:
  - RESET: alu_fs=5'h15, d_en=1, da_sel=2, so SP_REG is loaded with 0x3FC. Next: FETCH.
  - FETCH: im_cs, im_rd, ir_ld, pc_inc. Next: DECODE.
  - DECODE: select on ir[31:26]:
    - 0x00 goes to EXEC_R.
    - 0x08/0x0A/0x0C/0x0D/0x0E/0x0F go to EXEC_I.
    - 0x23/0x2B go to MEM_ADDR.
    - 0x04/0x05 go to BR_CMP.
    - 0x02 goes to JUMP.
    - Any other value goes to HALT.
  - EXEC_R: select on funct:
    - 0x20→02, 0x21→03, 0x22→04, 0x23→05.
    - 0x24→08, 0x25→09, 0x26→0A, 0x27→0B.
    - 0x2A→06, 0x2B→07.
    - 0x02→0C, 0x03→0D, 0x00→0E.
    - Illegal funct goes to HALT.
    - Flags latch into psr. Next: WB_ALU.
  - EXEC_I: t_sel=1. alu_fs is selected by opcode: addi 02, slti 06, andi 16, ori 17, xori 19, lui 18. Flags latch. Next: WB_ALU.
  - WB_ALU: hold the EXEC alu_fs and t_sel. d_en=1, y_sel=0. da_sel=0 for R-type, 1 for I-type. Next: FETCH.
  - MEM_ADDR: alu_fs=02, t_sel=1. Next: LW_RD for lw, SW_WR for sw.
  - LW_RD: keep address operands; dm_cs, dm_rd. Next: LW_WB.
  - LW_WB: dm_cs, dm_rd, d_en, y_sel=1, da_sel=1. Next: FETCH.
  - SW_WR: keep address operands; dm_cs, dm_wr. Next: FETCH.
  - BR_CMP: alu_fs=04 (rs−rt); psr latches. Next: BR_TAKE if (beq and z) or (bne and !z), else FETCH.
  - BR_TAKE: pc_sel=1, pc_ld. Next: FETCH.
  - JUMP: pc_sel=2, pc_ld. Next: FETCH.
  - HALT: halt=1. Stays in HALT until reset.
- psr updates only in EXEC_R, EXEC_I and BR_CMP. It holds in all other states.

## Timing
- On reset high at any clock edge, the next state is RESET and psr=0, regardless of the current state, including mid-LW_RD or SW_WR. dm_wr drops in that same cycle.
- Reset values: state=RESET, psr=4'b0. Outputs during RESET: alu_fs=5'h15, d_en=1, da_sel=2; all others 0.
- Latency in clocks, FETCH to next FETCH:
  - R/I-type: 4
  - lw: 5
  - sw: 4
  - branch not taken: 3
  - branch taken: 4
  - j: 3
- dm_wr is asserted for exactly one cycle per sw.
- d_en is asserted for exactly one cycle per writing instruction.
- The branch decision uses the z input in BR_CMP combinationally. The latched psr is observation only.
- With reset held, the unit stays in RESET and d_en remains 1 every cycle.

## Structure
- Shared package/include holds:
  - The ALU FS codes (PASS_S..SP_INIT, 5'h00–5'h1F), reused by the ALU and this block.
  - Opcode and funct constants.
  - State encoding, 4-bit.
- Sub-module fs_decode: combinational mapping of {opcode, funct} to alu_fs plus an illegal flag. It is used by EXEC_R, EXEC_I and WB_ALU.

## Test plan
- Reset released, then ir=0x00221820 (add $3,$1,$2) → state sequence RESET, FETCH, DECODE, EXEC_R, WB_ALU. In EXEC_R, alu_fs=5'h02. In WB_ALU, d_en=1, da_sel=0.
- ir=0x3C01ABCD (lui) → EXEC_I with alu_fs=5'h18, t_sel=1. WB_ALU with da_sel=1.
- ir=0x10220003 (beq):
  - z=1 in BR_CMP → BR_TAKE with pc_sel=1, pc_ld=1.
  - z=0 → FETCH directly.
- ir=0x8C220004 (lw) → dm_rd is high for 2 cycles and d_en=1 with y_sel=1 in LW_WB. Reset asserted during LW_RD → RESET on the next edge, with psr=0.
- ir=0xFC000000 (illegal opcode) → HALT with halt=1 for 10+ cycles. Only reset exits HALT.
- ir=0x00221821 with c=1 and z=1 in EXEC_R → psr=4'b1001 after the edge. psr is unchanged through the following FETCH.
